// File: rtl/fsm3_pkg.sv
// Shared encodings for the mod-3 residue scheduler: residue codes, controller states
// and the single-bit residue transition function.
package fsm3_pkg;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} ctrl_state_t;

    // A one adds 1 and a zero subtracts 1 (adds 2) modulo 3; the unused code 3 recovers to S0.
    function automatic logic [1:0] res_next(input logic [1:0] r, input logic b);
        logic [1:0] nxt;
        case (r)
            S0:      nxt = b ? S1 : S2;
            S1:      nxt = b ? S2 : S0;
            S2:      nxt = b ? S0 : S1;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fsm3_residue_core.sv
// Serial mod-3 residue engine: one bit per enabled clock, synchronous clear wins over enable.
module fsm3_residue_core
    import fsm3_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [1:0] residue
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            residue <= S0;
        end else if (clr) begin
            residue <= S0;
        end else if (en) begin
            residue <= res_next(residue, din);
        end
    end

endmodule

// File: rtl/fsm3_residue_sched.sv
// Round-robin scheduler that time-shares one serial mod-3 residue engine among N requesters
// and returns residue, match flag and requester id through a valid/ready response port.
module fsm3_residue_sched
    import fsm3_pkg::*;
#(
    parameter  int N   = 4,
    parameter  int W   = 8,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_data,
    output logic [N-1:0]     req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [1:0]       rsp_residue,
    output logic             rsp_match,
    output logic             busy
);

    localparam int CW = $clog2(W + 1);

    ctrl_state_t    state;
    logic [IDW-1:0] rr;
    logic [IDW-1:0] id;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] grant_inc;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   shreg;
    logic           found;
    logic           accept;
    logic [1:0]     residue;

    // First valid requester at or after the rr pointer, wrapping once around.
    always_comb begin
        int             idx;
        logic [IDW-1:0] sel;
        idx   = 0;
        sel   = '0;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr) + k;
            if (idx >= N) idx = idx - N;
            sel = IDW'(idx);
            if (!found && req_valid[sel]) begin
                found = 1'b1;
                grant = sel;
            end
        end
    end

    assign accept    = (state == IDLE) && found;
    assign grant_inc = (grant == IDW'(N - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_ready[i] = accept && (grant == IDW'(i));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            rr        <= '0;
            id        <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id    <= grant;
                        rr    <= grant_inc;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Word datapath: loaded on accept, drained LSB-first into the engine.
    always_ff @(posedge CLK) begin
        if (accept) begin
            shreg <= req_data[int'(grant)*W +: W];
        end else if (state == SHIFT) begin
            shreg <= shreg >> 1;
        end
    end

    fsm3_residue_core u_core (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (accept),
        .en      (state == SHIFT),
        .din     (shreg[0]),
        .residue (residue)
    );

    assign rsp_id      = id;
    assign rsp_residue = residue;
    assign rsp_match   = (residue == S2);

endmodule

// File: tb/tb_fsm3_residue_sched.sv
// Bench for fsm3_residue_sched: vector table, hand-written corner sequences and a randomized
// phase against a round-robin / ones-minus-zeros reference model.
module tb_fsm3_residue_sched;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_data = '0;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [IDW-1:0]   rsp_id;
    logic [1:0]       rsp_residue;
    logic             rsp_match;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         idx;
        logic [W-1:0] word;
        int         res;
        int         m;
    } vec_t;

    typedef struct {
        int id;
        int res;
    } rsp_t;

    rsp_t pend[$];

    fsm3_residue_sched #(.N(N), .W(W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_residue (rsp_residue),
        .rsp_match   (rsp_match),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Residue is (#ones - #zeros) mod 3, folded into 0..2.
    function automatic int ref_res(input logic [W-1:0] w);
        int ones;
        ones = $countones(w);
        return (((2 * ones - W) % 3) + 3) % 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Called at a negedge with requests already driven. Waits for the grant, checks it,
    // then waits for the response and checks its fields. Returns at the negedge where
    // rsp_valid was first seen; lat counts edges from the accept edge to that response.
    task automatic serve(input int idx, input int exp_res, input bit keep, input string nm,
                         output int lat, output longint t_acc);
        bit got;
        lat   = -1;
        t_acc = 0;
        got   = 1'b0;
        for (int t = 0; t < 40; t++) begin
            #1;
            if (req_ready != '0) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!got) begin
            chk({nm, " grant timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({nm, " req_ready"}, 32'(req_ready), 32'(1) << idx);
        @(posedge CLK);
        t_acc = longint'($time);
        @(negedge CLK);
        if (!keep) req_valid[idx] = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (rsp_valid) begin
                got = 1'b1;
                lat = t;
                break;
            end
            @(negedge CLK);
        end
        if (!got) begin
            chk({nm, " response timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({nm, " rsp_id"}, 32'(rsp_id), 32'(idx));
        chk({nm, " rsp_residue"}, 32'(rsp_residue), 32'(exp_res));
        chk({nm, " rsp_match"}, 32'(rsp_match), (exp_res == 2) ? 32'd1 : 32'd0);
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    initial begin
        vec_t   tbl[5];
        int     lat;
        longint ta, tb;
        int     seen;
        int     ptr;
        int     gl;
        int     g;

        tbl[0] = '{0, 8'hFF, 2, 1};
        tbl[1] = '{1, 8'h00, 1, 0};
        tbl[2] = '{2, 8'h01, 0, 0};
        tbl[3] = '{3, 8'h07, 1, 0};
        tbl[4] = '{0, 8'hF0, 0, 0};

        // Reset state
        do_reset();
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_id", 32'(rsp_id), 32'd0);
        chk("reset rsp_residue", 32'(rsp_residue), 32'd0);
        chk("reset rsp_match", 32'(rsp_match), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);

        // Single-request vectors
        for (int i = 0; i < 5; i++) begin
            req_data[tbl[i].idx*W +: W] = tbl[i].word;
            req_valid = '0;
            req_valid[tbl[i].idx] = 1'b1;
            rsp_ready = 1'b1;
            serve(tbl[i].idx, tbl[i].res, 1'b0, $sformatf("vec%0d", i), lat, ta);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(W));
            chk($sformatf("vec%0d match flag", i), 32'(rsp_match), 32'(tbl[i].m));
            chk($sformatf("vec%0d busy in resp", i), 32'(busy), 32'd1);
        end
        @(negedge CLK);
        #1;
        chk("vec rsp_valid drops", 32'(rsp_valid), 32'd0);
        chk("vec busy drops", 32'(busy), 32'd0);

        // All four valid from reset: strict round-robin order
        do_reset();
        req_data  = {8'h01, 8'hFF, 8'h00, 8'h1F};
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        serve(0, 2, 1'b0, "all4 r0", lat, ta);
        serve(1, 1, 1'b0, "all4 r1", lat, ta);
        serve(2, 2, 1'b0, "all4 r2", lat, ta);
        serve(3, 0, 1'b0, "all4 r3", lat, ta);

        // Response stall: fields stable, no new grant, exactly one response
        do_reset();
        req_data  = {8'h00, 8'h00, 8'h00, 8'hFF};
        req_valid = 4'b0011;
        rsp_ready = 1'b0;
        serve(0, 2, 1'b0, "stall r0", lat, ta);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            #1;
            chk($sformatf("stall c%0d rsp_valid", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("stall c%0d rsp_id", c), 32'(rsp_id), 32'd0);
            chk($sformatf("stall c%0d rsp_residue", c), 32'(rsp_residue), 32'd2);
            chk($sformatf("stall c%0d req_ready", c), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge CLK);
        #1;
        chk("stall rsp_valid after accept", 32'(rsp_valid), 32'd0);
        serve(1, 1, 1'b0, "stall r1", lat, ta);

        // Reset during SHIFT discards the word and resets the rr pointer
        do_reset();
        req_data  = {8'h00, 8'h00, 8'h00, 8'h55};
        req_valid = 4'b0011;
        rsp_ready = 1'b1;
        #1;
        chk("rst-mid grant", 32'(req_ready), 32'd1);
        @(posedge CLK);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST       = 1'b1;
        req_valid = '0;
        #1;
        chk("rst-mid busy", 32'(busy), 32'd0);
        chk("rst-mid rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst-mid rsp_residue", 32'(rsp_residue), 32'd0);
        @(negedge CLK);
        RST  = 1'b0;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge CLK);
            if (rsp_valid) seen++;
        end
        chk("rst-mid no response", 32'(seen), 32'd0);
        req_data[0 +: W] = 8'hFF;
        req_valid = 4'b0011;
        serve(0, 2, 1'b0, "rst-mid r0", lat, ta);
        serve(1, 1, 1'b0, "rst-mid r1", lat, ta);

        // Requesters 1 and 3 continuously valid: alternate with no bubbles
        do_reset();
        req_data  = {8'hF0, 8'h00, 8'h07, 8'h00};
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        serve(1, 1, 1'b1, "alt a", lat, ta);
        serve(3, 0, 1'b1, "alt b", lat, tb);
        chk("alt interval a-b", 32'((tb - ta) / 10), 32'(W + 2));
        serve(1, 1, 1'b1, "alt c", lat, ta);
        chk("alt interval b-c", 32'((ta - tb) / 10), 32'(W + 2));
        serve(3, 0, 1'b1, "alt d", lat, tb);
        chk("alt interval c-d", 32'((tb - ta) / 10), 32'(W + 2));
        req_valid = '0;
        @(negedge CLK);

        // Randomized traffic against the reference model
        do_reset();
        pend.delete();
        ptr = 0;
        gl  = -1;
        for (int c = 0; c < 3000; c++) begin
            if (gl >= 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    req_data[gl*W +: W] = W'($urandom);
                end else begin
                    req_valid[gl] = 1'b0;
                end
                gl = -1;
            end
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_data[i*W +: W] = W'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (rsp_valid) begin
                if (pend.size() == 0) begin
                    chk("rand spurious response", 32'd1, 32'd0);
                end else begin
                    chk("rand rsp_id", 32'(rsp_id), 32'(pend[0].id));
                    chk("rand rsp_residue", 32'(rsp_residue), 32'(pend[0].res));
                    chk("rand rsp_match", 32'(rsp_match), (pend[0].res == 2) ? 32'd1 : 32'd0);
                    if (rsp_ready) void'(pend.pop_front());
                end
            end
            if (req_ready != '0) begin
                g = pick(req_valid, ptr);
                chk("rand grant", 32'(req_ready), (g < 0) ? 32'd0 : (32'(1) << g));
                chk("rand grant while pending", 32'(pend.size()), 32'd0);
                if (g >= 0) begin
                    pend.push_back('{g, ref_res(req_data[g*W +: W])});
                    ptr = (g + 1) % N;
                    gl  = g;
                end
            end
            @(negedge CLK);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 60 && pend.size() != 0; c++) begin
            #1;
            if (rsp_valid) begin
                chk("drain rsp_id", 32'(rsp_id), 32'(pend[0].id));
                chk("drain rsp_residue", 32'(rsp_residue), 32'(pend[0].res));
                void'(pend.pop_front());
            end
            @(negedge CLK);
        end
        chk("drain all responses returned", 32'(pend.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
